// File: rtl/qsys_system_heart_rate_in_if.sv
// Avalon-MM slave bus bundle for the heart-rate input port; readdata is combinational (readLatency 0).
// No waitrequest: every access completes in the cycle it is presented.
interface qsys_system_heart_rate_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/qsys_system_heart_rate_in.sv
// Heart-rate sample capture port: 2-flop sync, DATA/STATUS/IRQMASK/EDGECAP registers, level irq.
// Sample visible 2 clk after in_valid is first sampled; reads zero-wait, no backpressure.
module qsys_system_heart_rate_in #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  qsys_system_heart_rate_in_if.slave  avs,
  input  logic [DATA_WIDTH-1:0]       in_port,
  input  logic                        in_valid,
  output logic                        irq
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;

  logic [DATA_WIDTH-1:0] s1_port, s2_port, s3_port;
  logic                  s1_valid, s2_valid, s3_valid;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] edge_cap;
  logic                  new_flag, ovr_flag;
  logic [1:0]            irq_mask;

  logic                  valid_pulse;
  logic [DATA_WIDTH-1:0] bit_rise;
  logic                  wr_en, wr_status, wr_mask, wr_edge;
  logic                  unused_wdata;

  // s3 resets to 0 so a strobe already high at reset release still yields one pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_port  <= '0;
      s2_port  <= '0;
      s3_port  <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_port  <= in_port;
      s2_port  <= s1_port;
      s3_port  <= s2_port;
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  assign valid_pulse = s2_valid & ~s3_valid;
  assign bit_rise    = s2_port & ~s3_port;

  assign wr_en        = avs.chipselect & ~avs.write_n;
  assign wr_status    = wr_en && (avs.address == ADDR_STATUS);
  assign wr_mask      = wr_en && (avs.address == ADDR_MASK);
  assign wr_edge      = wr_en && (avs.address == ADDR_EDGE);
  assign unused_wdata = ^avs.writedata[31:2];

  // Every set term is OR-ed after its clear term, so a set always beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= '0;
      new_flag <= 1'b0;
      ovr_flag <= 1'b0;
      irq_mask <= 2'b00;
      edge_cap <= '0;
    end else begin
      if (valid_pulse) begin
        data_reg <= s2_port;
      end
      new_flag <= valid_pulse | (new_flag & ~(wr_status & avs.writedata[0]));
      ovr_flag <= (valid_pulse & new_flag) | (ovr_flag & ~(wr_status & avs.writedata[1]));
      if (wr_mask) begin
        irq_mask <= avs.writedata[1:0];
      end
      edge_cap <= (wr_edge ? '0 : edge_cap) | bit_rise;
    end
  end

  assign irq = (new_flag & irq_mask[0]) | (ovr_flag & irq_mask[1]);

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      ADDR_DATA:   avs.readdata[DATA_WIDTH-1:0] = data_reg;
      ADDR_STATUS: avs.readdata[1:0]            = {ovr_flag, new_flag};
      ADDR_MASK:   avs.readdata[1:0]            = irq_mask;
      ADDR_EDGE:   avs.readdata[DATA_WIDTH-1:0] = edge_cap;
      default:     avs.readdata                 = '0;
    endcase
  end

endmodule

// File: tb/tb_qsys_system_heart_rate_in.sv
// Bench for qsys_system_heart_rate_in: table-driven scenarios, hand-timed corner cases,
// then random traffic against a transaction-level model of the register map.
module tb_qsys_system_heart_rate_in;

  localparam int K_SAMPLE = 0;
  localparam int K_PORT   = 1;
  localparam int K_WRITE  = 2;
  localparam int K_READ   = 3;
  localparam int K_IRQ    = 4;

  typedef struct {
    int          kind;
    logic [1:0]  addr;
    logic [31:0] dat;
    logic [31:0] exp;
  } step_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_port;
  logic       in_valid;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;

  qsys_system_heart_rate_in_if bus ();

  qsys_system_heart_rate_in #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus.slave),
    .in_port  (in_port),
    .in_valid (in_valid),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  // Assumes the current time is just after a rising edge; write is sampled at the next one.
  task automatic wr_now(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    tick();
    wr_now(a, d);
  endtask

  task automatic send_sample(input logic [7:0] v);
    in_port = v;
    repeat (3) tick();
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_port(input logic [7:0] v);
    in_port = v;
    repeat (4) tick();
  endtask

  step_t tbl[$];

  logic [31:0] r;
  logic [7:0]  m_data, m_edge, m_port;
  logic        m_new, m_ovr;
  logic [1:0]  m_mask;

  initial begin
    reset_n        = 1'b0;
    in_port        = '0;
    in_valid       = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    tbl.push_back('{K_READ,   2'd0, 32'h0,        32'h0});
    tbl.push_back('{K_READ,   2'd1, 32'h0,        32'h0});
    tbl.push_back('{K_READ,   2'd2, 32'h0,        32'h0});
    tbl.push_back('{K_READ,   2'd3, 32'h0,        32'h0});
    tbl.push_back('{K_IRQ,    2'd0, 32'h0,        32'h0});
    tbl.push_back('{K_WRITE,  2'd2, 32'h1,        32'h0});
    tbl.push_back('{K_SAMPLE, 2'd0, 32'h48,       32'h0});
    tbl.push_back('{K_READ,   2'd0, 32'h0,        32'h48});
    tbl.push_back('{K_READ,   2'd1, 32'h0,        32'h1});
    tbl.push_back('{K_IRQ,    2'd0, 32'h0,        32'h1});
    tbl.push_back('{K_WRITE,  2'd1, 32'h1,        32'h0});
    tbl.push_back('{K_READ,   2'd1, 32'h0,        32'h0});
    tbl.push_back('{K_IRQ,    2'd0, 32'h0,        32'h0});
    tbl.push_back('{K_WRITE,  2'd2, 32'h2,        32'h0});
    tbl.push_back('{K_SAMPLE, 2'd0, 32'h48,       32'h0});
    tbl.push_back('{K_SAMPLE, 2'd0, 32'h4A,       32'h0});
    tbl.push_back('{K_READ,   2'd0, 32'h0,        32'h4A});
    tbl.push_back('{K_READ,   2'd1, 32'h0,        32'h3});
    tbl.push_back('{K_IRQ,    2'd0, 32'h0,        32'h1});
    tbl.push_back('{K_WRITE,  2'd1, 32'h2,        32'h0});
    tbl.push_back('{K_READ,   2'd1, 32'h0,        32'h1});
    tbl.push_back('{K_IRQ,    2'd0, 32'h0,        32'h0});
    tbl.push_back('{K_WRITE,  2'd1, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{K_READ,   2'd1, 32'h0,        32'h0});
    tbl.push_back('{K_PORT,   2'd0, 32'h00,       32'h0});
    tbl.push_back('{K_WRITE,  2'd3, 32'h0,        32'h0});
    tbl.push_back('{K_READ,   2'd3, 32'h0,        32'h0});
    tbl.push_back('{K_PORT,   2'd0, 32'h81,       32'h0});
    tbl.push_back('{K_PORT,   2'd0, 32'h01,       32'h0});
    tbl.push_back('{K_PORT,   2'd0, 32'h03,       32'h0});
    tbl.push_back('{K_READ,   2'd3, 32'h0,        32'h83});
    tbl.push_back('{K_WRITE,  2'd3, 32'h0,        32'h0});
    tbl.push_back('{K_READ,   2'd3, 32'h0,        32'h0});
    tbl.push_back('{K_READ,   2'd2, 32'h0,        32'h2});
    tbl.push_back('{K_WRITE,  2'd2, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{K_READ,   2'd2, 32'h0,        32'h3});
    tbl.push_back('{K_WRITE,  2'd0, 32'hAA,       32'h0});
    tbl.push_back('{K_READ,   2'd0, 32'h0,        32'h4A});

    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].kind)
        K_SAMPLE: send_sample(tbl[i].dat[7:0]);
        K_PORT:   set_port(tbl[i].dat[7:0]);
        K_WRITE:  bus_write(tbl[i].addr, tbl[i].dat);
        K_READ: begin
          tick();
          rd(tbl[i].addr, r);
          check($sformatf("tbl%0d read a%0d", i, tbl[i].addr), r, tbl[i].exp);
        end
        default: begin
          tick();
          check($sformatf("tbl%0d irq", i), {31'd0, irq}, tbl[i].exp);
        end
      endcase
    end

    // Latency: first sampled at edge N, DATA/NEW update at edge N+2.
    bus_write(2'd2, 32'h1);
    in_port = 8'h11;
    repeat (3) tick();
    in_valid = 1'b1;
    tick();
    rd(2'd0, r); check("lat N data", r, 32'h4A);
    tick();
    rd(2'd0, r); check("lat N+1 data", r, 32'h4A);
    check("lat N+1 irq", {31'd0, irq}, 32'h0);
    tick();
    rd(2'd0, r); check("lat N+2 data", r, 32'h11);
    rd(2'd1, r); check("lat N+2 status", r, 32'h1);
    check("lat N+2 irq", {31'd0, irq}, 32'h1);
    in_valid = 1'b0;
    repeat (3) tick();

    // W1C of NEW in the exact cycle valid_pulse is high.
    in_port = 8'h22;
    repeat (3) tick();
    in_valid = 1'b1;
    tick();
    tick();
    wr_now(2'd1, 32'h1);
    rd(2'd1, r); check("setclr status", r, 32'h3);
    rd(2'd0, r); check("setclr data", r, 32'h22);
    in_valid = 1'b0;
    repeat (3) tick();
    bus_write(2'd1, 32'h3);

    // EDGECAP write in the same cycle bit2 rises.
    bus_write(2'd3, 32'h0);
    set_port(8'h00);
    set_port(8'h03);
    rd(2'd3, r); check("edge pre", r, 32'h03);
    in_port = 8'h07;
    tick();
    tick();
    wr_now(2'd3, 32'hDEAD);
    rd(2'd3, r); check("edge wr+rise", r, 32'h04);

    // Asynchronous reset mid-cycle with DATA=0x55, NEW=1.
    send_sample(8'h55);
    rd(2'd0, r); check("pre-rst data", r, 32'h55);
    check("pre-rst irq", {31'd0, irq}, 32'h1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst irq", {31'd0, irq}, 32'h0);
    rd(2'd0, r); check("rst data", r, 32'h0);
    rd(2'd1, r); check("rst status", r, 32'h0);
    rd(2'd2, r); check("rst mask", r, 32'h0);
    rd(2'd3, r); check("rst edge", r, 32'h0);

    // Strobe held high through reset release: exactly one capture.
    in_port  = 8'h3C;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (5) tick();
    rd(2'd0, r); check("rel data", r, 32'h3C);
    rd(2'd1, r); check("rel status", r, 32'h1);
    bus_write(2'd1, 32'h1);
    repeat (10) tick();
    rd(2'd1, r); check("rel no 2nd", r, 32'h0);
    in_valid = 1'b0;
    repeat (3) tick();

    // Random traffic from a clean reset against the register-map model.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    in_port = '0;
    #4;
    reset_n = 1'b1;
    repeat (3) tick();
    m_data = '0; m_edge = '0; m_port = '0; m_new = 1'b0; m_ovr = 1'b0; m_mask = '0;

    for (int it = 0; it < 80; it++) begin
      logic [7:0]  v;
      logic [31:0] d;
      int          op;
      op = $urandom_range(0, 5);
      v  = 8'($urandom_range(0, 255));
      d  = $urandom;
      case (op)
        0: begin
          send_sample(v);
          m_edge = m_edge | (v & ~m_port);
          m_port = v;
          if (m_new) m_ovr = 1'b1;
          m_new  = 1'b1;
          m_data = v;
        end
        1: begin
          set_port(v);
          m_edge = m_edge | (v & ~m_port);
          m_port = v;
        end
        2: begin
          bus_write(2'd1, d);
          if (d[0]) m_new = 1'b0;
          if (d[1]) m_ovr = 1'b0;
        end
        3: begin
          bus_write(2'd2, d);
          m_mask = d[1:0];
        end
        4: begin
          bus_write(2'd3, d);
          m_edge = '0;
        end
        default: bus_write(2'd0, d);
      endcase
      rd(2'd0, r); check($sformatf("rnd%0d data", it), r, {24'd0, m_data});
      rd(2'd1, r); check($sformatf("rnd%0d status", it), r, {30'd0, m_ovr, m_new});
      rd(2'd2, r); check($sformatf("rnd%0d mask", it), r, {30'd0, m_mask});
      rd(2'd3, r); check($sformatf("rnd%0d edge", it), r, {24'd0, m_edge});
      check($sformatf("rnd%0d irq", it), {31'd0, irq},
            {31'd0, (m_new & m_mask[0]) | (m_ovr & m_mask[1])});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
